// File: rtl/branch_resolve_id_if.sv
// Pipeline-side bundle for the ID-stage branch resolution unit.
// master: pipeline driving ID/forwarding state and consuming stall/redirect.
// slave : the branch resolution unit.
interface branch_resolve_id_if #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned CNT_W      = 16
);
    // ID-stage instruction
    logic                  id_valid;
    logic [31:0]           instruction;
    logic [WIDTH-1:0]      pc_plus4;
    logic [WIDTH-1:0]      readData1;
    logic [WIDTH-1:0]      readData2;
    // forwarding sources and downstream control
    logic [WIDTH-1:0]      aluResult_ex;
    logic [WIDTH-1:0]      aluResult_mem;
    logic [WIDTH-1:0]      writeDataToReg;
    logic                  ex_regwrite;
    logic                  ex_memread;
    logic [REG_ADDR_W-1:0] ex_dest;
    logic                  mem_regwrite;
    logic                  mem_memread;
    logic [REG_ADDR_W-1:0] mem_dest;
    logic                  wb_regwrite;
    logic [REG_ADDR_W-1:0] wb_dest;
    // results
    logic                  stall_id;
    logic                  branch_taken;
    logic [WIDTH-1:0]      branch_target;
    logic                  flush_if;
    logic [CNT_W-1:0]      stall_count;
    logic [CNT_W-1:0]      taken_count;

    modport master (
        output id_valid, instruction, pc_plus4, readData1, readData2,
               aluResult_ex, aluResult_mem, writeDataToReg,
               ex_regwrite, ex_memread, ex_dest,
               mem_regwrite, mem_memread, mem_dest,
               wb_regwrite, wb_dest,
        input  stall_id, branch_taken, branch_target, flush_if,
               stall_count, taken_count
    );

    modport slave (
        input  id_valid, instruction, pc_plus4, readData1, readData2,
               aluResult_ex, aluResult_mem, writeDataToReg,
               ex_regwrite, ex_memread, ex_dest,
               mem_regwrite, mem_memread, mem_dest,
               wb_regwrite, wb_dest,
        output stall_id, branch_taken, branch_target, flush_if,
               stall_count, taken_count
    );
endinterface

// File: rtl/branch_resolve_id.sv
// Decode-stage branch resolution for the 5-stage MIPS pipeline.
// Resolves beq/bne/bgt/blt in ID from forwarded operands, stalls IF/ID on a
// load-use hazard against a branch source, registers the taken pulse, target
// and IF flush, ignores the wrong-path slot after a taken branch, and keeps
// saturating stall/taken event counters.
// Ports: clk, reset (async active-low), bus (slave side of branch_resolve_id_if):
//   stall_id is combinational; branch_taken/flush_if/branch_target and the
//   counters are registered.
module branch_resolve_id #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned SIGNED_CMP = 0,
    parameter int unsigned CNT_W      = 16
) (
    input logic               clk,
    input logic               reset,
    branch_resolve_id_if.slave bus
);
    localparam logic [5:0] OP_BEQ = 6'h04;
    localparam logic [5:0] OP_BNE = 6'h05;
    localparam logic [5:0] OP_BLT = 6'h06;
    localparam logic [5:0] OP_BGT = 6'h07;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_HOLD  = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               branch_taken_q, branch_taken_d;
    logic [WIDTH-1:0]   branch_target_q, branch_target_d;
    logic [CNT_W-1:0]   stall_count_q, stall_count_d;
    logic [CNT_W-1:0]   taken_count_q, taken_count_d;

    logic [5:0]            opcode;
    logic [REG_ADDR_W-1:0] src [2];
    logic [WIDTH-1:0]      rf_val [2];
    logic [WIDTH-1:0]      opnd [2];
    logic [1:0]            src_haz;
    logic                  hazard;
    logic                  is_branch;
    logic                  cond;
    logic                  cmp_gt;
    logic                  cmp_lt;
    logic [WIDTH-1:0]      imm_ext;
    logic [WIDTH-1:0]      target;
    logic                  active;
    logic                  stall_c;
    logic                  resolve_taken;

    // Source specifiers and register-file values for rs (0) and rt (1)
    always_comb begin
        src[0]    = REG_ADDR_W'(bus.instruction[25:21]);
        src[1]    = REG_ADDR_W'(bus.instruction[20:16]);
        rf_val[0] = bus.readData1;
        rf_val[1] = bus.readData2;
    end

    // Operand forwarding (nearest producer wins) and load-use hazard detection
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            opnd[i]    = rf_val[i];
            src_haz[i] = 1'b0;
            if (src[i] == '0) begin
                opnd[i] = '0;
            end else if (bus.ex_regwrite && !bus.ex_memread && bus.ex_dest == src[i]) begin
                opnd[i] = bus.aluResult_ex;
            end else if (bus.mem_regwrite && !bus.mem_memread && bus.mem_dest == src[i]) begin
                opnd[i] = bus.aluResult_mem;
            end else if (bus.wb_regwrite && bus.wb_dest == src[i]) begin
                opnd[i] = bus.writeDataToReg;
            end
            // Load data is not available until WB, so a loading producer stalls
            if (src[i] != '0) begin
                src_haz[i] = (bus.ex_regwrite && bus.ex_memread && bus.ex_dest == src[i]) ||
                             (bus.mem_regwrite && bus.mem_memread && bus.mem_dest == src[i]);
            end
        end
        hazard = |src_haz;
    end

    // Branch decode, comparison and target
    always_comb begin
        opcode    = bus.instruction[31:26];
        is_branch = 1'b0;
        cond      = 1'b0;
        if (SIGNED_CMP != 0) begin
            cmp_gt = $signed(opnd[0]) > $signed(opnd[1]);
            cmp_lt = $signed(opnd[0]) < $signed(opnd[1]);
        end else begin
            cmp_gt = opnd[0] > opnd[1];
            cmp_lt = opnd[0] < opnd[1];
        end
        case (opcode)
            OP_BEQ: begin is_branch = 1'b1; cond = (opnd[0] == opnd[1]); end
            OP_BNE: begin is_branch = 1'b1; cond = (opnd[0] != opnd[1]); end
            OP_BGT: begin is_branch = 1'b1; cond = cmp_gt; end
            OP_BLT: begin is_branch = 1'b1; cond = cmp_lt; end
            default: begin is_branch = 1'b0; cond = 1'b0; end
        endcase
        imm_ext = WIDTH'($signed(bus.instruction[15:0]));
        target  = bus.pc_plus4 + (imm_ext << 2);
    end

    // Next state, stall and register updates
    always_comb begin
        state_d         = state_q;
        branch_target_d = branch_target_q;
        stall_count_d   = stall_count_q;
        taken_count_d   = taken_count_q;

        // The slot after a taken branch is wrong-path and never stalls or resolves
        active        = reset && (state_q != S_FLUSH) && bus.id_valid && is_branch;
        stall_c       = active && hazard;
        resolve_taken = active && !hazard && cond;

        case (state_q)
            S_IDLE: begin
                if (stall_c) begin
                    state_d = S_HOLD;
                end else if (resolve_taken) begin
                    state_d = S_FLUSH;
                end
            end
            S_HOLD: begin
                if (!bus.id_valid) begin
                    state_d = S_IDLE;
                end else if (stall_c) begin
                    state_d = S_HOLD;
                end else if (resolve_taken) begin
                    state_d = S_FLUSH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FLUSH: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        branch_taken_d = (state_d == S_FLUSH);
        if (resolve_taken) begin
            branch_target_d = target;
        end
        if (stall_c && stall_count_q != '1) begin
            stall_count_d = stall_count_q + CNT_W'(1);
        end
        if (resolve_taken && taken_count_q != '1) begin
            taken_count_d = taken_count_q + CNT_W'(1);
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= S_IDLE;
            branch_taken_q  <= 1'b0;
            branch_target_q <= '0;
            stall_count_q   <= '0;
            taken_count_q   <= '0;
        end else begin
            state_q         <= state_d;
            branch_taken_q  <= branch_taken_d;
            branch_target_q <= branch_target_d;
            stall_count_q   <= stall_count_d;
            taken_count_q   <= taken_count_d;
        end
    end

    assign bus.stall_id      = stall_c;
    assign bus.branch_taken  = branch_taken_q;
    assign bus.flush_if      = branch_taken_q;
    assign bus.branch_target = branch_target_q;
    assign bus.stall_count   = stall_count_q;
    assign bus.taken_count   = taken_count_q;
endmodule

// File: tb/tb_branch_resolve_id.sv
// Bench for branch_resolve_id: two instances share one stimulus stream,
// u_dut0 with unsigned compares and 16-bit counters, u_dut1 with signed
// compares and 4-bit counters. Expected taken targets are queued per
// instance; a negedge monitor pops them on every branch_taken pulse.
module tb_branch_resolve_id;
    localparam logic [5:0] OP_BEQ = 6'h04;
    localparam logic [5:0] OP_BNE = 6'h05;
    localparam logic [5:0] OP_BLT = 6'h06;
    localparam logic [5:0] OP_BGT = 6'h07;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        id_valid;
    logic [31:0] instruction, pc_plus4, rd1, rd2, alu_ex, alu_mem, wdata;
    logic        ex_rw, ex_mr, mem_rw, mem_mr, wb_rw;
    logic [4:0]  ex_dest, mem_dest, wb_dest;

    branch_resolve_id_if #(.WIDTH(32), .REG_ADDR_W(5), .CNT_W(16)) b0 ();
    branch_resolve_id_if #(.WIDTH(32), .REG_ADDR_W(5), .CNT_W(4))  b1 ();

    assign b0.id_valid = id_valid;        assign b1.id_valid = id_valid;
    assign b0.instruction = instruction;  assign b1.instruction = instruction;
    assign b0.pc_plus4 = pc_plus4;        assign b1.pc_plus4 = pc_plus4;
    assign b0.readData1 = rd1;            assign b1.readData1 = rd1;
    assign b0.readData2 = rd2;            assign b1.readData2 = rd2;
    assign b0.aluResult_ex = alu_ex;      assign b1.aluResult_ex = alu_ex;
    assign b0.aluResult_mem = alu_mem;    assign b1.aluResult_mem = alu_mem;
    assign b0.writeDataToReg = wdata;     assign b1.writeDataToReg = wdata;
    assign b0.ex_regwrite = ex_rw;        assign b1.ex_regwrite = ex_rw;
    assign b0.ex_memread = ex_mr;         assign b1.ex_memread = ex_mr;
    assign b0.ex_dest = ex_dest;          assign b1.ex_dest = ex_dest;
    assign b0.mem_regwrite = mem_rw;      assign b1.mem_regwrite = mem_rw;
    assign b0.mem_memread = mem_mr;       assign b1.mem_memread = mem_mr;
    assign b0.mem_dest = mem_dest;        assign b1.mem_dest = mem_dest;
    assign b0.wb_regwrite = wb_rw;        assign b1.wb_regwrite = wb_rw;
    assign b0.wb_dest = wb_dest;          assign b1.wb_dest = wb_dest;

    branch_resolve_id #(.WIDTH(32), .REG_ADDR_W(5), .SIGNED_CMP(0), .CNT_W(16)) u_dut0 (
        .clk(clk), .reset(reset), .bus(b0)
    );
    branch_resolve_id #(.WIDTH(32), .REG_ADDR_W(5), .SIGNED_CMP(1), .CNT_W(4)) u_dut1 (
        .clk(clk), .reset(reset), .bus(b1)
    );

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] q0 [$];
    logic [31:0] q1 [$];
    logic [31:0] exp0, exp1;

    function automatic logic [31:0] enc(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clr();
        id_valid = 1'b0; instruction = '0; pc_plus4 = '0; rd1 = '0; rd2 = '0;
        alu_ex = '0; alu_mem = '0; wdata = '0;
        ex_rw = 1'b0; ex_mr = 1'b0; ex_dest = '0;
        mem_rw = 1'b0; mem_mr = 1'b0; mem_dest = '0;
        wb_rw = 1'b0; wb_dest = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every pulse must match the oldest queued target
    always @(negedge clk) begin
        if (b0.branch_taken) begin
            vectors++;
            if (q0.size() == 0) begin
                miscompares++;
                $display("FAIL dut0_pulse: unexpected pulse target 0x%0h, required no pulse", b0.branch_target);
            end else begin
                exp0 = q0.pop_front();
                if (b0.branch_target !== exp0 || b0.flush_if !== 1'b1) begin
                    miscompares++;
                    $display("FAIL dut0_pulse: target 0x%0h flush %0b, required target 0x%0h flush 1",
                             b0.branch_target, b0.flush_if, exp0);
                end
            end
        end
        if (b1.branch_taken) begin
            vectors++;
            if (q1.size() == 0) begin
                miscompares++;
                $display("FAIL dut1_pulse: unexpected pulse target 0x%0h, required no pulse", b1.branch_target);
            end else begin
                exp1 = q1.pop_front();
                if (b1.branch_target !== exp1 || b1.flush_if !== 1'b1) begin
                    miscompares++;
                    $display("FAIL dut1_pulse: target 0x%0h flush %0b, required target 0x%0h flush 1",
                             b1.branch_target, b1.flush_if, exp1);
                end
            end
        end
    end

    initial begin
        clr();
        reset = 1'b0;
        // Reset with a hazarding branch present: everything quiet
        id_valid = 1'b1; instruction = enc(OP_BEQ, 5'd3, 5'd0, 16'h0);
        ex_rw = 1'b1; ex_mr = 1'b1; ex_dest = 5'd3;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall0", 32'(b0.stall_id), 32'd0);
        chk("rst_stall1", 32'(b1.stall_id), 32'd0);
        chk("rst_taken", 32'(b0.branch_taken), 32'd0);
        chk("rst_flush", 32'(b0.flush_if), 32'd0);
        chk("rst_target", b0.branch_target, 32'd0);
        chk("rst_stall_cnt", 32'(b0.stall_count), 32'd0);
        chk("rst_taken_cnt", 32'(b0.taken_count), 32'd0);
        clr();
        step();
        reset = 1'b1;

        // beq 5==5, pc+4=0x100, imm=3 -> 0x10C
        step();
        id_valid = 1'b1; instruction = enc(OP_BEQ, 5'd1, 5'd2, 16'h0003);
        rd1 = 32'd5; rd2 = 32'd5; pc_plus4 = 32'h100;
        q0.push_back(32'h10C); q1.push_back(32'h10C);
        #1 chk("beq_no_stall", 32'(b0.stall_id), 32'd0);
        step(); clr();
        #1 chk("beq_taken_cnt0", 32'(b0.taken_count), 32'd1);
        chk("beq_taken_cnt1", 32'(b1.taken_count), 32'd1);
        step();

        // bgt 0xFFFFFFFF > 1: unsigned taken, signed not taken
        id_valid = 1'b1; instruction = enc(OP_BGT, 5'd1, 5'd2, 16'h0010);
        rd1 = 32'hFFFF_FFFF; rd2 = 32'd1; pc_plus4 = 32'h200;
        q0.push_back(32'h240);
        step(); clr();
        #1 chk("bgt_taken_cnt0", 32'(b0.taken_count), 32'd2);
        chk("bgt_taken_cnt1", 32'(b1.taken_count), 32'd1);
        chk("bgt_signed_nopulse", 32'(b1.branch_taken), 32'd0);
        step();

        // Load to r3 in EX with bne r3,r0 in ID: stall 2, resolve via WB
        id_valid = 1'b1; instruction = enc(OP_BNE, 5'd3, 5'd0, 16'h0002);
        pc_plus4 = 32'h300; ex_rw = 1'b1; ex_mr = 1'b1; ex_dest = 5'd3;
        #1 chk("lu_stall_n", 32'(b0.stall_id), 32'd1);
        step();
        ex_rw = 1'b0; ex_mr = 1'b0; ex_dest = '0;
        mem_rw = 1'b1; mem_mr = 1'b1; mem_dest = 5'd3;
        #1 chk("lu_stall_n1", 32'(b0.stall_id), 32'd1);
        step();
        mem_rw = 1'b0; mem_mr = 1'b0; mem_dest = '0;
        wb_rw = 1'b1; wb_dest = 5'd3; wdata = 32'd7;
        q0.push_back(32'h308); q1.push_back(32'h308);
        #1 chk("lu_stall_n2", 32'(b0.stall_id), 32'd0);
        step(); clr();
        #1 chk("lu_stall_cnt0", 32'(b0.stall_count), 32'd2);
        chk("lu_stall_cnt1", 32'(b1.stall_count), 32'd2);
        step();

        // EX beats MEM and WB for r4: beq r4,r5 with 9==9
        id_valid = 1'b1; instruction = enc(OP_BEQ, 5'd4, 5'd5, 16'h0001);
        pc_plus4 = 32'h400; rd1 = 32'd0; rd2 = 32'd9;
        ex_rw = 1'b1; ex_dest = 5'd4; alu_ex = 32'd9;
        mem_rw = 1'b1; mem_dest = 5'd4; alu_mem = 32'd2;
        wb_rw = 1'b1; wb_dest = 5'd4; wdata = 32'd1;
        q0.push_back(32'h404); q1.push_back(32'h404);
        step(); clr(); step();

        // r0 reads as 0 even with an EX write to r0 and a garbage RF value
        id_valid = 1'b1; instruction = enc(OP_BEQ, 5'd0, 5'd6, 16'h0000);
        pc_plus4 = 32'h500; rd1 = 32'h55; rd2 = 32'd0;
        ex_rw = 1'b1; ex_dest = 5'd0; alu_ex = 32'h77;
        q0.push_back(32'h500); q1.push_back(32'h500);
        step(); clr(); step();

        // Taken beq imm=0xFFFF, wrong-path beq in FLUSH, then back-to-back beq
        id_valid = 1'b1; instruction = enc(OP_BEQ, 5'd1, 5'd2, 16'hFFFF);
        rd1 = 32'd5; rd2 = 32'd5; pc_plus4 = 32'h600;
        q0.push_back(32'h5FC); q1.push_back(32'h5FC);
        step();
        instruction = enc(OP_BEQ, 5'd1, 5'd2, 16'h0010); pc_plus4 = 32'h604;
        ex_rw = 1'b1; ex_mr = 1'b1; ex_dest = 5'd1;
        #1 chk("flush_no_stall", 32'(b0.stall_id), 32'd0);
        chk("flush_pulse_level", 32'(b0.branch_taken), 32'd1);
        step(); clr();
        id_valid = 1'b1; instruction = enc(OP_BEQ, 5'd1, 5'd2, 16'h0001);
        rd1 = 32'd5; rd2 = 32'd5; pc_plus4 = 32'h700;
        q0.push_back(32'h704); q1.push_back(32'h704);
        #1 chk("b2b_gap", 32'(b0.branch_taken), 32'd0);
        step(); clr(); step();

        // Not-taken bne, hazarding non-branch, then blt 1 < 0xFFFFFFFF
        id_valid = 1'b1; instruction = enc(OP_BNE, 5'd1, 5'd2, 16'h0040);
        rd1 = 32'd5; rd2 = 32'd5; pc_plus4 = 32'h800;
        #1 chk("bne_nt_no_stall", 32'(b0.stall_id), 32'd0);
        step(); clr();
        id_valid = 1'b1; instruction = enc(6'h08, 5'd3, 5'd0, 16'h0000);
        ex_rw = 1'b1; ex_mr = 1'b1; ex_dest = 5'd3;
        #1 chk("nonbranch_no_stall", 32'(b0.stall_id), 32'd0);
        step(); clr();
        id_valid = 1'b1; instruction = enc(OP_BLT, 5'd1, 5'd2, 16'h0004);
        rd1 = 32'd1; rd2 = 32'hFFFF_FFFF; pc_plus4 = 32'h900;
        q0.push_back(32'h910);
        step(); clr();
        #1 chk("taken_cnt0", 32'(b0.taken_count), 32'd8);
        chk("taken_cnt1", 32'(b1.taken_count), 32'd6);
        chk("blt_signed_nopulse", 32'(b1.branch_taken), 32'd0);
        step();

        // Reset asserted while in HOLD aborts with no later pulse
        id_valid = 1'b1; instruction = enc(OP_BEQ, 5'd3, 5'd0, 16'h0008);
        pc_plus4 = 32'hA00; ex_rw = 1'b1; ex_mr = 1'b1; ex_dest = 5'd3;
        #1 chk("hold_stall_a", 32'(b0.stall_id), 32'd1);
        step();
        ex_rw = 1'b0; ex_mr = 1'b0; ex_dest = '0;
        mem_rw = 1'b1; mem_mr = 1'b1; mem_dest = 5'd3;
        #1 chk("hold_stall_b", 32'(b0.stall_id), 32'd1);
        #1 reset = 1'b0;
        #1 chk("rst_hold_stall", 32'(b0.stall_id), 32'd0);
        chk("rst_hold_taken", 32'(b0.branch_taken), 32'd0);
        chk("rst_hold_stall_cnt", 32'(b0.stall_count), 32'd0);
        chk("rst_hold_taken_cnt", 32'(b0.taken_count), 32'd0);
        step(); clr(); step();
        reset = 1'b1;
        repeat (3) step();
        chk("post_rst_quiet", 32'(b0.branch_taken), 32'd0);

        // 2^4+5 stall cycles: 4-bit counter saturates, 16-bit counter does not
        id_valid = 1'b1; instruction = enc(OP_BEQ, 5'd3, 5'd0, 16'h0000);
        ex_rw = 1'b1; ex_mr = 1'b1; ex_dest = 5'd3;
        repeat (21) step();
        clr();
        #1 chk("sat_stall_cnt0", 32'(b0.stall_count), 32'd21);
        chk("sat_stall_cnt1", 32'(b1.stall_count), 32'd15);
        repeat (3) step();

        chk("q0_drained", q0.size(), 32'd0);
        chk("q1_drained", q1.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
